// File: rtl/dec_entry_pkg.sv
// Shared types and helpers for the decimal entry block.
// States, the radix and the signed magnitude limit.
package dec_entry_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    ACCUM,
    HOLD,
    ERR
  } dec_state_e;

  localparam int unsigned DEC_RADIX = 10;

  // Largest magnitude representable for the given sign.
  function automatic int dec_limit(input logic neg, input int width);
    int half;
    half = 1 << (width - 1);
    return neg ? half : half - 1;
  endfunction

endpackage

// File: rtl/dec_mac10.sv
// Combinational mag*10+digit with overflow test.
// Headroom of four bits keeps the product exact.
module dec_mac10
  import dec_entry_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] mag,
  input  logic [3:0]       digit,
  input  logic             neg,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH+3:0] m;
  logic [WIDTH+3:0] prod;
  logic [WIDTH+3:0] lim;

  assign m    = {4'b0, mag};
  assign prod = (m << 3) + (m << 1) + {{WIDTH{1'b0}}, digit};
  assign lim  = (WIDTH+4)'(dec_limit(neg, WIDTH));
  assign ovf  = prod > lim;
  assign sum  = prod[WIDTH-1:0];

endmodule

// File: rtl/dec_entry.sv
// Decimal key entry: digits, sign, clear, enter
// into a signed operand handed off by valid/ready.
module dec_entry
  import dec_entry_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       digit_in,
  input  logic             digit_stb,
  input  logic             neg_stb,
  input  logic             clear_stb,
  input  logic             enter_stb,
  output logic [WIDTH-1:0] entry_value,
  output logic             entry_active,
  output logic [WIDTH-1:0] out_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  dec_state_e       state, state_n;
  logic [WIDTH-1:0] mag, mag_n;
  logic             neg, neg_n;
  logic [CW-1:0]    count, cnt_n;
  logic [3:0]       dig, dig_n;
  logic [WIDTH-1:0] outv_n, ev_n;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic             dig_ok;
  logic [WIDTH-1:0] lim_flip;

  dec_mac10 #(.WIDTH(WIDTH)) u_mac (
    .mag   (mag),
    .digit (dig),
    .neg   (neg),
    .sum   (sum),
    .ovf   (ovf)
  );

  assign dig_ok   = digit_in < 4'(DEC_RADIX);
  assign lim_flip = WIDTH'(dec_limit(~neg, WIDTH));

  always_comb begin
    state_n = state;
    mag_n   = mag;
    neg_n   = neg;
    cnt_n   = count;
    dig_n   = dig;
    outv_n  = out_value;
    if (clear_stb) begin
      state_n = IDLE;
      mag_n   = '0;
      neg_n   = 1'b0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enter_stb) begin
            state_n = IDLE;
          end else if (neg_stb) begin
            neg_n   = ~neg;
            state_n = ENTRY;
          end else if (digit_stb && dig_ok) begin
            dig_n   = digit_in;
            state_n = ACCUM;
          end
        end
        ENTRY: begin
          if (enter_stb) begin
            outv_n  = neg ? -mag : mag;
            state_n = HOLD;
          end else if (neg_stb) begin
            // Flipping -128 to +128 is not representable.
            if (mag > lim_flip) state_n = ERR;
            else neg_n = ~neg;
          end else if (digit_stb && dig_ok
                       && count < CW'(MAX_DIGITS)) begin
            dig_n   = digit_in;
            state_n = ACCUM;
          end
        end
        ACCUM: begin
          if (ovf) begin
            state_n = ERR;
          end else begin
            mag_n   = sum;
            cnt_n   = count + CW'(1);
            state_n = ENTRY;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_n = IDLE;
            mag_n   = '0;
            neg_n   = 1'b0;
            cnt_n   = '0;
          end
        end
        ERR: state_n = ERR;
        default: state_n = IDLE;
      endcase
    end
    ev_n = neg_n ? -mag_n : mag_n;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      mag         <= '0;
      neg         <= 1'b0;
      count       <= '0;
      dig         <= '0;
      out_value   <= '0;
      entry_value <= '0;
    end else begin
      state       <= state_n;
      mag         <= mag_n;
      neg         <= neg_n;
      count       <= cnt_n;
      dig         <= dig_n;
      out_value   <= outv_n;
      entry_value <= ev_n;
    end
  end

  assign entry_active = (state != IDLE) && (state != HOLD);
  assign out_valid    = (state == HOLD);
  assign err          = (state == ERR);

endmodule
